mmio_arbiter: RTL and testbench



---
 rtl/mmio_arb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 35 +++
 rtl/mmio_arbiter.sv | 136 +++++++++++++
 tb/tb_mmio_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_arb_pkg.sv
// rtl/mmio_arb_pkg.sv - shared widths, lock FSM encoding and master indices for mmio_arbiter
package mmio_arb_pkg;

    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ARB   = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with one-hot grant and lock override
module rr_arb2
    import mmio_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       lock_force,
    input  logic       lock_idx,
    output logic [1:0] gnt
);

    logic last_gnt;

    // A held lock masks the other requester entirely rather than just biasing priority.
    always_comb begin
        gnt = 2'b00;
        if (lock_force) begin
            gnt[lock_idx] = req[lock_idx];
        end else if (req == 2'b11) begin
            gnt[~last_gnt] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= M1;
        end else if (|gnt) begin
            last_gnt <= gnt[1];
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// rtl/mmio_arbiter.sv - shares the mmio_xbar CPU port between M0 and M1; MMIO_ARB_LOCK_EN adds bus locking
module mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_m0_req,
    input  logic [ADDR_W-1:0]   i_m0_addr,
    input  logic [DATA_W-1:0]   i_m0_data,
    input  logic [DATA_W/8-1:0] i_m0_mask,
    input  logic                i_m0_wren,
    output logic                o_m0_gnt,
    output logic                o_m0_rvalid,
    output logic [DATA_W-1:0]   o_m0_rdata,
    input  logic                i_m1_req,
    input  logic [ADDR_W-1:0]   i_m1_addr,
    input  logic [DATA_W-1:0]   i_m1_data,
    input  logic [DATA_W/8-1:0] i_m1_mask,
    input  logic                i_m1_wren,
    output logic                o_m1_gnt,
    output logic                o_m1_rvalid,
    output logic [DATA_W-1:0]   o_m1_rdata,
    output logic [ADDR_W-1:0]   o_mmio_addr,
    output logic [DATA_W-1:0]   o_mmio_data,
    output logic [DATA_W/8-1:0] o_mmio_mask,
    output logic                o_mmio_wren,
    input  logic [DATA_W-1:0]   i_mmio_data
`ifdef MMIO_ARB_LOCK_EN
    ,
    input  logic                i_m0_lock,
    input  logic                i_m1_lock
`endif
);

    logic [1:0]        gnt;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              lock_force;
    logic              lock_idx;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rd_beat;

    assign lock_force = (state != ARB);
    assign lock_idx   = (state == LOCK1) ? M1 : M0;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        ({i_m1_req, i_m0_req}),
        .lock_force (lock_force),
        .lock_idx   (lock_idx),
        .gnt        (gnt)
    );

    assign o_m0_gnt = gnt[0];
    assign o_m1_gnt = gnt[1];

    // Ungranted cycles drive an all-zero bus so the xbar never sees a stray write.
    always_comb begin
        o_mmio_addr = '0;
        o_mmio_data = '0;
        o_mmio_mask = '0;
        o_mmio_wren = 1'b0;
        if (gnt[0]) begin
            o_mmio_addr = i_m0_addr;
            o_mmio_data = i_m0_data;
            o_mmio_mask = i_m0_mask;
            o_mmio_wren = i_m0_wren;
        end else if (gnt[1]) begin
            o_mmio_addr = i_m1_addr;
            o_mmio_data = i_m1_data;
            o_mmio_mask = i_m1_mask;
            o_mmio_wren = i_m1_wren;
        end
    end

`ifdef MMIO_ARB_LOCK_EN
    always_comb begin
        state_nxt = state;
        case (state)
            ARB: begin
                if (gnt[0] && i_m0_lock) begin
                    state_nxt = LOCK0;
                end else if (gnt[1] && i_m1_lock) begin
                    state_nxt = LOCK1;
                end
            end
            LOCK0: begin
                if (!i_m0_req || (gnt[0] && !i_m0_lock)) begin
                    state_nxt = ARB;
                end
            end
            LOCK1: begin
                if (!i_m1_req || (gnt[1] && !i_m1_lock)) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end
`else
    assign state_nxt = ARB;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    assign rd_beat = {gnt[1] & ~i_m1_wren, gnt[0] & ~i_m0_wren};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_beat;
            if (|rd_beat) begin
                rdata_q <= i_mmio_data;
            end
        end
    end

    assign o_m0_rvalid = rvalid_q[0];
    assign o_m1_rvalid = rvalid_q[1];
    assign o_m0_rdata  = rdata_q;
    assign o_m1_rdata  = rdata_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb/tb_mmio_arbiter.sv - scoreboard bench for mmio_arbiter; lock checks build under MMIO_ARB_LOCK_EN
module tb_mmio_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk;
    logic          rst_n;
    logic          m0_req, m1_req, m0_wren, m1_wren;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_data, m1_data;
    logic [MW-1:0] m0_mask, m1_mask;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mmio_addr;
    logic [DW-1:0] mmio_data;
    logic [MW-1:0] mmio_mask;
    logic          mmio_wren;
    logic [DW-1:0] mmio_rd;
`ifdef MMIO_ARB_LOCK_EN
    logic          m0_lock, m1_lock;
`endif

    mmio_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_m0_req    (m0_req),
        .i_m0_addr   (m0_addr),
        .i_m0_data   (m0_data),
        .i_m0_mask   (m0_mask),
        .i_m0_wren   (m0_wren),
        .o_m0_gnt    (m0_gnt),
        .o_m0_rvalid (m0_rvalid),
        .o_m0_rdata  (m0_rdata),
        .i_m1_req    (m1_req),
        .i_m1_addr   (m1_addr),
        .i_m1_data   (m1_data),
        .i_m1_mask   (m1_mask),
        .i_m1_wren   (m1_wren),
        .o_m1_gnt    (m1_gnt),
        .o_m1_rvalid (m1_rvalid),
        .o_m1_rdata  (m1_rdata),
        .o_mmio_addr (mmio_addr),
        .o_mmio_data (mmio_data),
        .o_mmio_mask (mmio_mask),
        .o_mmio_wren (mmio_wren),
        .i_mmio_data (mmio_rd)
`ifdef MMIO_ARB_LOCK_EN
        ,
        .i_m0_lock   (m0_lock),
        .i_m1_lock   (m1_lock)
`endif
    );

    typedef struct {
        int            cyc;
        bit            m;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
        bit            wren;
    } beat_t;

    typedef struct {
        int            cyc;
        bit            m;
        logic [DW-1:0] data;
    } rd_t;

    beat_t beat_q[$];
    rd_t   rd_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;

    bit            p_req[2];
    logic [AW-1:0] p_addr[2];
    logic [DW-1:0] p_data[2];
    logic [MW-1:0] p_mask[2];
    bit            p_wren[2];
    bit            p_lock[2];

    bit m_last;
    int m_lock;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply();
        m0_req  = p_req[0];  m1_req  = p_req[1];
        m0_addr = p_addr[0]; m1_addr = p_addr[1];
        m0_data = p_data[0]; m1_data = p_data[1];
        m0_mask = p_mask[0]; m1_mask = p_mask[1];
        m0_wren = p_wren[0]; m1_wren = p_wren[1];
`ifdef MMIO_ARB_LOCK_EN
        m0_lock = p_lock[0]; m1_lock = p_lock[1];
`endif
    endtask

    // Reference: a lock owner excludes the other master; otherwise a lone requester wins
    // and a tie goes to whoever was not served last.
    function automatic int model_grant(input bit r0, input bit r1);
        if (m_lock >= 0) return ((m_lock == 0) ? r0 : r1) ? m_lock : -1;
        if (r0 && r1) return m_last ? 0 : 1;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic step(input logic [DW-1:0] rd_val, output int g);
        beat_t b;
        rd_t   r;
        apply();
        mmio_rd = rd_val;
        g = model_grant(p_req[0], p_req[1]);
        if (g >= 0) begin
            b.cyc = cyc; b.m = g[0]; b.addr = p_addr[g]; b.data = p_data[g];
            b.mask = p_mask[g]; b.wren = p_wren[g];
            beat_q.push_back(b);
            if (!p_wren[g]) begin
                r.cyc = cyc + 1; r.m = g[0]; r.data = rd_val;
                rd_q.push_back(r);
            end
            m_last = g[0];
        end
`ifdef MMIO_ARB_LOCK_EN
        if (m_lock >= 0) begin
            if (!p_req[m_lock] || (g == m_lock && !p_lock[g])) m_lock = -1;
        end else if (g >= 0 && p_lock[g]) begin
            m_lock = g;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic new_beat(input int m);
        p_req[m]  = 1'b1;
        p_addr[m] = AW'($urandom);
        p_data[m] = $urandom;
        p_mask[m] = MW'($urandom);
        p_wren[m] = 1'($urandom_range(0, 1));
`ifdef MMIO_ARB_LOCK_EN
        p_lock[m] = ($urandom_range(0, 3) == 0);
`else
        p_lock[m] = 1'b0;
`endif
    endtask

    task automatic clear_masters();
        for (int m = 0; m < 2; m++) begin
            p_req[m] = 1'b0; p_addr[m] = '0; p_data[m] = '0;
            p_mask[m] = '0; p_wren[m] = 1'b0; p_lock[m] = 1'b0;
        end
        apply();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_masters();
        mmio_rd = '0;
        beat_q.delete();
        rd_q.delete();
        m_last = 1'b1;
        m_lock = -1;
        #1;
        chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
        chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 64'h0);
        chk("rst_wren", mmio_wren, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        beat_t e;
        rd_t   r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m0_gnt || m1_gnt) begin
                    if (beat_q.size() == 0) begin
                        chk("unexpected_gnt", {m1_gnt, m0_gnt}, 2'b00);
                    end else begin
                        e = beat_q.pop_front();
                        chk("gnt_cycle", cyc, e.cyc);
                        chk("gnt_owner", {m1_gnt, m0_gnt}, e.m ? 2'b10 : 2'b01);
                        chk("bus_beat", {mmio_wren, mmio_mask, mmio_addr, mmio_data},
                            {e.wren, e.mask, e.addr, e.data});
                    end
                end else begin
                    chk("idle_bus", {mmio_wren, mmio_mask, mmio_addr, mmio_data}, 0);
                end
                if (m0_rvalid || m1_rvalid) begin
                    if (rd_q.size() == 0) begin
                        chk("unexpected_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
                    end else begin
                        r = rd_q.pop_front();
                        chk("rvalid_cycle", cyc, r.cyc);
                        chk("rvalid_owner", {m1_rvalid, m0_rvalid}, r.m ? 2'b10 : 2'b01);
                        chk("rdata", r.m ? m1_rdata : m0_rdata, r.data);
                    end
                end
            end
        end
    end

    initial begin
        int g;
        rst_n = 1'b0;
        do_reset();

        // single-master write
        p_req[0] = 1; p_addr[0] = '0; p_data[0] = 32'h1234; p_mask[0] = 4'hF; p_wren[0] = 1;
        step($urandom, g);
        chk("wr_model_gnt", g, 0);
        chk("wr_no_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        clear_masters();

        // read latency gnt+1, only owner sees rvalid
        p_req[1] = 1; p_addr[1] = '0; p_wren[1] = 0;
        step(32'hDEADBEEF, g);
        clear_masters();
        chk("rd_m1_rvalid", m1_rvalid, 1'b1);
        chk("rd_m1_rdata", m1_rdata, 32'hDEADBEEF);
        chk("rd_m0_rvalid", m0_rvalid, 1'b0);
        step($urandom, g);
        chk("rd_rvalid_once", m1_rvalid, 1'b0);

        // contention straight after reset: M0, M1, M0, M1
        do_reset();
        new_beat(0); new_beat(1);
        p_lock[0] = 0; p_lock[1] = 0;
        for (int i = 0; i < 4; i++) begin
            step($urandom, g);
            chk("contend_order", g, i % 2);
            new_beat(g);
            p_lock[g] = 0;
        end
        clear_masters();

        repeat (10) step($urandom, g);

        // reset the cycle after a read grant aborts its rvalid
        p_req[0] = 1; p_addr[0] = 30'h15; p_wren[0] = 0;
        step($urandom, g);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step($urandom, g);
            chk("rst_abort_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
        end
        new_beat(0); new_beat(1);
        p_lock[0] = 0; p_lock[1] = 0;
        step($urandom, g);
        chk("post_rst_first", g, 0);
        clear_masters();
        step($urandom, g);

`ifdef MMIO_ARB_LOCK_EN
        // M1 holds the bus for three beats while M0 waits
        do_reset();
        new_beat(1); p_lock[1] = 1;
        step($urandom, g);
        chk("lock_beat1", g, 1);
        new_beat(0); p_lock[0] = 0;
        new_beat(1); p_lock[1] = 1;
        step($urandom, g);
        chk("lock_beat2", g, 1);
        new_beat(1); p_lock[1] = 0;
        step($urandom, g);
        chk("lock_beat3", g, 1);
        p_req[1] = 0;
        step($urandom, g);
        chk("lock_release", g, 0);
        clear_masters();
        step($urandom, g);
`endif

        // randomized traffic against the reference
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!p_req[m] && $urandom_range(0, 1) == 1) new_beat(m);
                else if (p_req[m] && $urandom_range(0, 15) == 0) p_req[m] = 0;
            end
            step($urandom, g);
            if (g >= 0) begin
                p_req[g] = 0;
                if ($urandom_range(0, 3) != 0) new_beat(g);
            end
        end
        clear_masters();
        repeat (4) step($urandom, g);
        chk("drain_beats", beat_q.size(), 0);
        chk("drain_reads", rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
